// File: rtl/memory_ctrl.sv
// memory_ctrl: single-port load/store RAM with a fixed access latency and busy/done handshake.
// Operands are captured when a request is accepted; the access commits on the completion edge.
module memory_ctrl #(
  parameter int         DATA_W   = 8,
  parameter int         ADDR_W   = 8,
  parameter int         DEPTH    = 256,
  parameter int         LATENCY  = 4,
  parameter logic [2:0] OP_STORE = 3'b100,
  parameter logic [2:0] OP_LOAD  = 3'b101
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        instruction,
  input  logic [DATA_W-1:0] reg_alpha,
  input  logic [ADDR_W-1:0] reg_beta,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              addr_err,
  output logic              out_signal
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nxt;
  logic              accept, complete;
  logic [CNT_W-1:0]  cnt_p0;
  logic              store_p0;
  logic [DATA_W-1:0] data_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_L);
  endfunction

  assign busy     = (state == BUSY);
  assign in_range = addr_in_range(addr_p0);
  assign idx      = addr_p0[IDX_W-1:0];

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (instruction == OP_LOAD || instruction == OP_STORE) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt_p0 == '0) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt_p0 <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt_p0 <= CNT_LOAD;
      else if (busy && cnt_p0 != '0)
        cnt_p0 <= cnt_p0 - CNT_W'(1);
    end
  end

  // p0: operands captured at accept; later input changes cannot disturb the access in flight
  always_ff @(posedge clock) begin
    if (accept) begin
      store_p0 <= (instruction == OP_STORE);
      data_p0  <= reg_alpha;
      addr_p0  <= reg_beta;
    end
  end

  // completion: commit store / update load result, pulse done and addr_err
  always_ff @(posedge clock) begin
    if (reset) begin
      done       <= 1'b0;
      addr_err   <= 1'b0;
      out_signal <= 1'b0;
      data_out   <= '0;
    end else begin
      done     <= complete;
      addr_err <= complete && !in_range;
      if (complete) begin
        out_signal <= ~out_signal;
        if (!store_p0)
          data_out <= in_range ? mem[idx] : '0;
      end
    end
  end

  // A reset on the completion edge aborts the store, so it is gated here too
  always_ff @(posedge clock) begin
    if (!reset && complete && store_p0 && in_range)
      mem[idx] <= data_p0;
  end

endmodule

// File: tb/tb_memory_ctrl.sv
// Scoreboard bench for memory_ctrl: two instances (LATENCY=4/DEPTH=200 and LATENCY=1/DEPTH=256)
// driven by directed and random requests, checked against an edge-indexed reference model.
module tb_memory_ctrl;

  localparam logic [2:0] OP_ST = 3'b100;
  localparam logic [2:0] OP_LD = 3'b101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst   [2];
  logic [2:0] ins   [2];
  logic [7:0] alpha [2];
  logic [7:0] beta  [2];
  logic [7:0] dout  [2];
  logic       busy  [2];
  logic       done  [2];
  logic       aerr  [2];
  logic       osig  [2];

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t actual=%h required=%h", nm, g, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 4 : 1;
    localparam int DEP = (g == 0) ? 200 : 256;

    memory_ctrl #(
      .DATA_W(8), .ADDR_W(8), .DEPTH(DEP), .LATENCY(LAT), .OP_STORE(OP_ST), .OP_LOAD(OP_LD)
    ) u_dut (
      .clock(clk), .reset(rst[g]), .instruction(ins[g]), .reg_alpha(alpha[g]), .reg_beta(beta[g]),
      .data_out(dout[g]), .busy(busy[g]), .done(done[g]), .addr_err(aerr[g]), .out_signal(osig[g])
    );

    // Reference model: accesses are serialized, each completes LAT edges after its accept edge
    logic [7:0] m_mem [256];
    logic [8:0] sbq [$];
    bit         pend = 1'b0, p_st = 1'b0, done_e = 1'b0, err_e = 1'b0, tog = 1'b0;
    logic [7:0] p_addr = 8'h00, p_data = 8'h00, m_dout = 8'h00;
    int         edge_n = 0, comp_n = 0;

    always @(posedge clk) begin
      edge_n++;
      done_e = 1'b0;
      err_e  = 1'b0;
      if (rst[g]) begin
        pend   = 1'b0;
        tog    = 1'b0;
        m_dout = 8'h00;
        sbq.delete();
      end else if (pend) begin
        if (edge_n == comp_n) begin
          pend   = 1'b0;
          done_e = 1'b1;
          tog    = ~tog;
          err_e  = (int'(p_addr) >= DEP);
          if (p_st) begin
            if (!err_e) m_mem[p_addr] = p_data;
          end else begin
            m_dout = err_e ? 8'h00 : m_mem[p_addr];
          end
        end
      end else if (ins[g] == OP_ST || ins[g] == OP_LD) begin
        pend   = 1'b1;
        p_st   = (ins[g] == OP_ST);
        p_addr = beta[g];
        p_data = alpha[g];
        comp_n = edge_n + LAT;
        if (p_st)
          sbq.push_back({int'(p_addr) >= DEP, m_dout});
        else
          sbq.push_back({int'(p_addr) >= DEP, (int'(p_addr) >= DEP) ? 8'h00 : m_mem[p_addr]});
      end
    end

    logic [8:0] sb_e;
    always @(negedge clk) begin
      if (chk_en) begin
        chk("busy", g, 32'(busy[g]), 32'(pend));
        chk("done", g, 32'(done[g]), 32'(done_e));
        chk("addr_err", g, 32'(aerr[g]), 32'(err_e));
        chk("out_signal", g, 32'(osig[g]), 32'(tog));
        chk("data_out_hold", g, 32'(dout[g]), 32'(m_dout));
        if (done[g] === 1'b1) begin
          if (sbq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL spurious_done dut%0d t=%0t actual=done required=no_pending_access", g, $time);
          end else begin
            sb_e = sbq.pop_front();
            chk("sb_data", g, 32'(dout[g]), 32'(sb_e[7:0]));
            chk("sb_err", g, 32'(aerr[g]), 32'(sb_e[8]));
          end
        end
      end
    end
  end

  task automatic wait_idle(input int g);
    int k;
    for (k = 0; k < 40; k++) begin
      if ((g == 0) ? !g_dut[0].pend : !g_dut[1].pend) break;
      @(negedge clk);
    end
    n_cmp++;
    if (k == 40) begin
      n_fail++;
      $display("FAIL timeout dut%0d t=%0t actual=still_busy required=idle_within_40", g, $time);
    end
  endtask

  task automatic issue(input int g, input logic [2:0] op, input logic [7:0] a, input logic [7:0] d);
    ins[g]   = op;
    beta[g]  = a;
    alpha[g] = d;
    @(negedge clk);
    ins[g] = 3'b000;
    wait_idle(g);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; ins[d] = 3'b000; alpha[d] = 8'h00; beta[d] = 8'h00;
    end
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    for (int i = 0; i < 10; i++) begin
      ins[0] = (i % 2 == 1) ? 3'b111 : 3'b000;
      ins[1] = ins[0];
      @(negedge clk);
    end
    ins[0] = 3'b000;
    ins[1] = 3'b000;

    for (int a = 0; a < 200; a++) issue(0, OP_ST, 8'(a), 8'($urandom));
    for (int a = 0; a < 256; a++) issue(1, OP_ST, 8'(a), 8'($urandom));

    issue(0, OP_ST, 8'h10, 8'hA5);
    issue(0, OP_LD, 8'h10, 8'h00);

    ins[0] = OP_ST; beta[0] = 8'h20; alpha[0] = 8'h5A;
    @(negedge clk);
    ins[0] = OP_LD; beta[0] = 8'h30; alpha[0] = 8'hFF;
    repeat (4) @(negedge clk);
    ins[0] = 3'b000;
    wait_idle(0);
    issue(0, OP_LD, 8'h20, 8'h00);

    issue(0, OP_ST, 8'h00, 8'h77);
    issue(0, OP_ST, 8'hF0, 8'hEE);
    issue(0, OP_LD, 8'hF0, 8'h00);
    issue(0, OP_LD, 8'h00, 8'h00);

    issue(0, OP_ST, 8'h05, 8'h11);
    ins[0] = OP_ST; beta[0] = 8'h05; alpha[0] = 8'h3C;
    @(negedge clk);
    ins[0] = 3'b000;
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    wait_idle(0);
    issue(0, OP_LD, 8'h05, 8'h00);

    ins[1] = OP_LD; beta[1] = 8'h42;
    repeat (10) @(negedge clk);
    ins[1] = 3'b000;
    wait_idle(1);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 80; i++) begin
        int r;
        logic [2:0] op;
        r  = $urandom_range(0, 9);
        op = (r < 4) ? OP_ST : (r < 8) ? OP_LD : 3'($urandom_range(0, 7));
        issue(d, op, 8'($urandom), 8'($urandom));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
